// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-ported SPRAM word array between the
// instruction-fetch port (I) and the load/store port (D). One access per
// cycle, round-robin or D-priority with a starvation bound, and a one-cycle
// response pulse routed back to the requester that won.
module spram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int D_PRIO     = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [ADDR_W+1:0] i_addr,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [ADDR_W+1:0] d_addr,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_I    = 2'd1,
        RESP_D    = 2'd2
    } resp_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              gnt_i;
    logic              gnt_d;
    resp_e             resp_sel_q, resp_sel_d;
    logic              last_gnt_d_q, last_gnt_d_d;  // 1: D was granted most recently
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Byte-offset bits are meaningless for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Grant decision: single requester wins outright, conflicts go by policy.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (i_valid && d_valid) begin
                if (D_PRIO == 0) begin
                    if (last_gnt_d_q) gnt_i = 1'b1;
                    else              gnt_d = 1'b1;
                end else begin
                    if (starve_cnt_q == STARVE_LIM) gnt_i = 1'b1;
                    else                            gnt_d = 1'b1;
                end
            end else if (i_valid) begin
                gnt_i = 1'b1;
            end else if (d_valid) begin
                gnt_d = 1'b1;
            end
        end
    end

    // RAM drive and handshake; idle cycles keep presenting the last address.
    always_comb begin
        i_ready   = gnt_i;
        d_ready   = gnt_d;
        ram_addr  = addr_q;
        ram_wen   = 4'b0000;
        ram_wdata = d_wdata;
        if (gnt_i) begin
            ram_addr = i_addr[ADDR_W+1:2];
        end else if (gnt_d) begin
            ram_addr = d_addr[ADDR_W+1:2];
            ram_wen  = d_wstrb;
        end
    end

    // Next-state for response routing, fairness history and starvation count.
    always_comb begin
        resp_sel_d   = RESP_NONE;
        last_gnt_d_d = last_gnt_d_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = ram_addr;
        if (gnt_i) begin
            resp_sel_d   = RESP_I;
            last_gnt_d_d = 1'b0;
        end else if (gnt_d) begin
            resp_sel_d   = RESP_D;
            last_gnt_d_d = 1'b1;
        end
        if (!i_valid || gnt_i) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // State registers; reset leaves D as last winner so I takes the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_sel_q   <= RESP_NONE;
            last_gnt_d_q <= 1'b1;
            starve_cnt_q <= 4'd0;
            addr_q       <= '0;
        end else begin
            resp_sel_q   <= resp_sel_d;
            last_gnt_d_q <= last_gnt_d_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
        end
    end

    // Response pulse one cycle after the grant; suppressed while reset is held.
    always_comb begin
        i_rvalid = !rst && (resp_sel_q == RESP_I);
        d_rvalid = !rst && (resp_sel_q == RESP_D);
        i_rdata  = ram_rdata;
        d_rdata  = ram_rdata;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-port arbiter sharing the single-ported 128 kB SPRAM word array (32-bit data, 15-bit word address, 4-bit byte write enables, 1-cycle read latency) between the CPU instruction-fetch port (I) and the load/store port (D).
- Grants at most one access per cycle, using round-robin fairness.
- Returns a single-cycle response pulse to the winning requester one cycle after the access is accepted.
- Sits between the CPU core and the SPRAM macro wrapper.

Parameters:
- ADDR_W, 15: RAM word-address width. Requester byte address width is ADDR_W+2.
- D_PRIO, 0: tie-break policy. 0 = round-robin on every conflict. 1 = D always wins a conflict, but I is forced through after STARVE_MAX consecutive lost cycles.
- STARVE_MAX, 4: starvation bound for D_PRIO=1, range 1..15.

Ports:
- clk input 1: system clock. All logic is on the rising edge.
- rst input 1: synchronous reset, active-high.
- i_valid input 1: I request valid.
- i_ready output 1: I request accepted this cycle.
- i_addr input ADDR_W+2: I byte address. Bits [1:0] are ignored.
- i_rvalid output 1: I read data valid (one-cycle pulse).
- i_rdata output 32: I read data.
- d_valid input 1: D request valid.
- d_ready output 1: D request accepted this cycle.
- d_addr input ADDR_W+2: D byte address. Bits [1:0] are ignored.
- d_wstrb input 4: D byte write strobes. 0 means read.
- d_wdata input 32: D write data.
- d_rvalid output 1: D response pulse, issued for reads and for writes.
- d_rdata output 32: D read data. Undefined for write responses.
- ram_addr output ADDR_W: RAM word address.
- ram_wen output 4: RAM byte write enables.
- ram_wdata output 32: RAM write data.
- ram_rdata input 32: RAM read data, valid the cycle after the address is presented.

Behaviour:
- Handshake
  - A request transfers in a cycle where valid && ready.
  - ready is combinational from valid and the arbitration state. It is never asserted without the matching valid.
  - Requester holds addr, wstrb and wdata stable while valid && !ready.
  - Requesters may drop valid without a transfer. The arbiter tolerates this.
- Grant, combinational each cycle
  - Only one port valid: that port is granted.
  - Both valid, D_PRIO=0: grant the port that was not granted most recently (last_gnt register).
  - Both valid, D_PRIO=1: grant D, unless starve_cnt == STARVE_MAX, in which case grant I.
  - Neither valid: no grant. ram_wen=0. ram_addr holds its previous value (registered last address muxed through).
- RAM drive (combinational)
  - ram_addr = granted addr[ADDR_W+1:2].
  - ram_wdata = d_wdata.
  - ram_wen = d_wstrb only when D is granted, else 0. An I grant never writes.
- Response pipeline
  - Registered resp_sel is one of NONE, I, D; it is set from the grant.
  - The next cycle raises the matching *_rvalid for exactly one cycle.
  - *_rdata = ram_rdata, combinational pass-through, valid only while *_rvalid=1.
  - There is no response backpressure. Back-to-back grants give back-to-back responses, sustaining 1 access per cycle.
  - Ordering is strictly in grant order. i_rvalid and d_rvalid are never high in the same cycle.
- Arbitration state
  - last_gnt updates only on a grant.
  - starve_cnt (4 bits) increments when I is valid and loses. It clears on an I grant or when I is not valid, and saturates at STARVE_MAX.
- Read-after-write, same address
  - A D write in cycle N followed by any read of that word in cycle N+1 returns the new data.
  - This relies on SPRAM write-then-read ordering. No forwarding logic.
- Reset (rst=1 at an edge)
  - resp_sel=NONE, last_gnt=D (so I wins the first conflict), starve_cnt=0, stored ram_addr=0.
  - While rst=1: i_ready=d_ready=0, ram_wen=0, i_rvalid=d_rvalid=0.
  - Reset asserted while a response is pending: the response is dropped. No rvalid appears after reset deasserts.
- Bounds
  - Address bits above ADDR_W+1 do not exist.
  - Any address in range is legal. No error response.

Test Plan:
- Reset, then I only: i_addr=0x0, 0x4, 0x8 back-to-back → i_ready=1 in each cycle; i_rvalid in cycles +1,+2,+3; data equals preloaded words 0..2.
- D write then read: d_wstrb=4'b1111, d_addr=0x100, d_wdata=0xDEADBEEF; next cycle read 0x100 → d_rvalid for both; second d_rdata=0xDEADBEEF; ram_addr=0x40.
- Byte strobe: preload 0x11223344 at 0x200; write d_wstrb=4'b0100, d_wdata=0x00AB0000; read back → 0x11AB3344.
- Conflict with D_PRIO=0: I and D both valid continuously for 6 cycles → grants I,D,I,D,I,D; responses in the same order; never both rvalid in one cycle.
- Conflict with D_PRIO=1, STARVE_MAX=4: both valid continuously → D,D,D,D,I,D,D,D,D,I; I wait never exceeds 4 cycles.
- Reset mid-op: D read granted in cycle N, rst=1 in cycle N+1 → d_rvalid stays 0; after release, the first conflict grants I.
